// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer for the MIPS subset core: owns pc, ir, the trap flag and the
// retired-instruction counter, and decodes datapath strobes from state and ir.
//
// state  | meaning
// FETCH  | request instruction at pc, hold until mem_ready
// DECODE | classify ir, illegal encodings go to TRAP
// EXEC   | ALU operation; branches, j, jal and jr resolve here
// MEM    | lw/sw data access, hold until mem_ready
// WB     | single-cycle register-file write
// TRAP   | illegal instruction or misaligned jr; left only by reset
module mc_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_W        = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             alu_zero,
  input  logic [XLEN-1:0]  rs_data,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      ir,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             reg_we,
  output logic [1:0]       dst_sel,
  output logic [1:0]       wb_sel,
  output logic             alu_src_imm,
  output logic [1:0]       alu_mode,
  output logic [2:0]       state,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [XLEN-1:0]  PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] retired_q, retired_d;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       is_rtype, is_alu_r, is_jr, is_addi, is_lw, is_sw;
  logic       is_beq, is_bne, is_j, is_jal, is_legal;
  logic       br_taken, jr_misaligned;

  logic [XLEN-1:0] br_offset;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] j_target;

  assign opcode   = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign is_rtype = (opcode == OP_RTYPE);
  assign is_alu_r = is_rtype && ((funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                                 (funct == FN_OR)  || (funct == FN_SLT));
  assign is_jr    = is_rtype && (funct == FN_JR);
  assign is_addi  = (opcode == OP_ADDI);
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_j     = (opcode == OP_J);
  assign is_jal   = (opcode == OP_JAL);
  assign is_legal = is_alu_r | is_jr | is_addi | is_lw | is_sw | is_beq | is_bne | is_j | is_jal;

  // pc_q already points past the branch, so the offset is relative to pc+4
  assign br_offset     = {{(XLEN-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  assign br_target     = pc_q + br_offset;
  assign j_target      = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
  assign br_taken      = is_beq ? alu_zero : ~alu_zero;
  assign jr_misaligned = (rs_data[1:0] != 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    trap_d    = trap_q;
    retired_d = retired_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + PC_STEP;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_jr) begin
          if (jr_misaligned) begin
            state_d = S_TRAP;
            trap_d  = 1'b1;
          end else begin
            pc_d      = rs_data;
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_ONE;
          end
        end else if (is_alu_r || is_addi) begin
          state_d = S_WB;
        end else if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else begin
          if (is_j || is_jal) begin
            pc_d = j_target;
          end else if (br_taken) begin
            pc_d = br_target;
          end
          state_d   = S_FETCH;
          retired_d = retired_q + CNT_ONE;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (is_sw) begin
            state_d   = S_FETCH;
            retired_d = retired_q + CNT_ONE;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        state_d   = S_FETCH;
        retired_d = retired_q + CNT_ONE;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      ir_q      <= '0;
      trap_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      trap_q    <= trap_d;
      retired_q <= retired_d;
    end
  end

  // Strobes are forced low while reset is held so an in-flight access is dropped cleanly
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    reg_we       = 1'b0;
    dst_sel      = 2'd0;
    wb_sel       = 2'd0;
    alu_src_imm  = 1'b0;
    alu_mode     = 2'd0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
        end
        S_EXEC: begin
          if (is_rtype) begin
            alu_mode = 2'd2;
          end else if (is_addi || is_lw || is_sw) begin
            alu_src_imm = 1'b1;
            alu_mode    = 2'd0;
          end else if (is_beq || is_bne) begin
            alu_mode = 2'd1;
          end else if (is_jal) begin
            reg_we  = 1'b1;
            dst_sel = 2'd2;
            wb_sel  = 2'd2;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          alu_src_imm  = 1'b1;
          alu_mode     = 2'd0;
          mem_we       = is_sw;
        end
        S_WB: begin
          reg_we = 1'b1;
          if (is_rtype) begin
            dst_sel = 2'd1;
            wb_sel  = 2'd0;
          end else if (is_lw) begin
            dst_sel = 2'd0;
            wb_sel  = 2'd1;
          end else begin
            dst_sel = 2'd0;
            wb_sel  = 2'd0;
          end
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign state   = state_q;
  assign trap    = trap_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: directed scenarios plus randomized instruction streams
// compared against an instruction-level reference model.
module tb_mc_sequencer;

  localparam int CNT_W = 4;
  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] pc;
  logic [31:0] ir;
  logic        mem_req, mem_we, mem_addr_sel, reg_we, alu_src_imm, trap;
  logic [1:0]  dst_sel, wb_sel, alu_mode;
  logic [2:0]  state;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;

  mc_sequencer #(.XLEN(32), .RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .rs_data(rs_data), .pc(pc), .ir(ir), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .reg_we(reg_we), .dst_sel(dst_sel),
    .wb_sel(wb_sel), .alu_src_imm(alu_src_imm), .alu_mode(alu_mode), .state(state),
    .trap(trap), .retired(retired)
  );

  always #5 clock = ~clock;

  // Observations collected over one instruction
  int          obs_cycles, obs_regwe_cnt, obs_regwe_cyc, obs_memwe_cnt;
  int          obs_addrsel_cnt, obs_addrsel_bad, obs_imm_cnt, obs_sub_cnt;
  logic [1:0]  obs_dst, obs_wb;
  logic [31:0] obs_link;
  bit          obs_timeout;
  logic [2:0]  obs_states[$];

  typedef struct packed {
    logic        trap;
    logic        retire;
    logic [31:0] npc;
    logic [31:0] link;
    int          cycles;
    int          regwe;
    logic [1:0]  dst;
    logic [1:0]  wb;
    int          regwe_at;
    int          memwe;
    int          addrsel;
    int          imm_cyc;
    int          sub_cyc;
  } exp_t;

  // Instruction-level model: cycle cost, resulting pc and strobe totals from the ISA rules
  function automatic exp_t predict(input logic [31:0] cur_pc, input logic [31:0] instr,
                                   input int fw, input int mw, input logic az,
                                   input logic [31:0] rsd);
    exp_t e;
    logic [31:0] pc4;
    logic [5:0] op, fn;
    bit taken;
    e = '0;
    pc4 = cur_pc + 32'd4;
    op = instr[31:26];
    fn = instr[5:0];
    e.npc = pc4;
    e.link = pc4;
    e.retire = 1'b1;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A) begin
          e.cycles = 4 + fw; e.regwe = 1; e.dst = 2'd1; e.wb = 2'd0; e.regwe_at = 4 + fw;
        end else if (fn == 6'h08) begin
          e.cycles = 3 + fw;
          if (rsd % 4 != 0) begin e.trap = 1'b1; e.retire = 1'b0; end
          else e.npc = rsd;
        end else begin
          e.cycles = 2 + fw; e.trap = 1'b1; e.retire = 1'b0;
        end
      end
      6'h08: begin
        e.cycles = 4 + fw; e.regwe = 1; e.dst = 2'd0; e.wb = 2'd0; e.regwe_at = 4 + fw;
        e.imm_cyc = 1;
      end
      6'h23: begin
        e.cycles = 5 + fw + mw; e.regwe = 1; e.dst = 2'd0; e.wb = 2'd1; e.regwe_at = 5 + fw + mw;
        e.addrsel = mw + 1; e.imm_cyc = mw + 2;
      end
      6'h2B: begin
        e.cycles = 4 + fw + mw; e.memwe = mw + 1; e.addrsel = mw + 1; e.imm_cyc = mw + 2;
      end
      6'h04, 6'h05: begin
        taken = (op == 6'h04) ? (az == 1'b1) : (az == 1'b0);
        e.cycles = 3 + fw; e.sub_cyc = 1;
        if (taken) e.npc = pc4 + 32'(int'($signed(instr[15:0])) * 4);
      end
      6'h02, 6'h03: begin
        e.cycles = 3 + fw;
        e.npc = (pc4 & 32'hF000_0000) + (32'(instr[25:0]) * 4);
        if (op == 6'h03) begin
          e.regwe = 1; e.dst = 2'd2; e.wb = 2'd2; e.regwe_at = 3 + fw;
        end
      end
      default: begin
        e.cycles = 2 + fw; e.trap = 1'b1; e.retire = 1'b0;
      end
    endcase
    return e;
  endfunction

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  // Drives one instruction from FETCH until the sequencer is back in FETCH or in TRAP
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw,
                           input logic az, input logic [31:0] rsd);
    int fseen, mseen;
    logic [2:0] s;
    bit done;
    fseen = 0; mseen = 0; done = 0;
    obs_cycles = 0; obs_regwe_cnt = 0; obs_regwe_cyc = 0; obs_memwe_cnt = 0;
    obs_addrsel_cnt = 0; obs_addrsel_bad = 0; obs_imm_cnt = 0; obs_sub_cnt = 0;
    obs_dst = '0; obs_wb = '0; obs_link = '0;
    obs_states.delete();
    mem_rdata = instr; alu_zero = az; rs_data = rsd;
    while (!done && obs_cycles < 200) begin
      @(negedge clock);
      obs_cycles++;
      s = state;
      obs_states.push_back(s);
      if (reg_we) begin
        obs_regwe_cnt++; obs_regwe_cyc = obs_cycles; obs_dst = dst_sel; obs_wb = wb_sel; obs_link = pc;
      end
      if (mem_we) obs_memwe_cnt++;
      if (mem_req && mem_addr_sel) obs_addrsel_cnt++;
      if (mem_addr_sel && s != 3'd3) obs_addrsel_bad++;
      if (alu_src_imm) obs_imm_cnt++;
      if (alu_mode == 2'd1) obs_sub_cnt++;
      if (mem_req && !mem_addr_sel) begin
        mem_ready = (fseen >= fw); fseen++;
      end else if (mem_req) begin
        mem_ready = (mseen >= mw); mseen++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clock); #1;
      if (state == 3'd7 || (s != 3'd0 && state == 3'd0)) done = 1;
    end
    obs_timeout = !done;
    mem_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clock);
    mem_ready = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, reg_we} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: got %b expected 000", {mem_req, mem_we, reg_we});
    end
    checks++;
    if (pc !== RV || ir !== 32'h0 || state !== 3'd0 || trap !== 1'b0 || retired !== 4'd0) begin
      errors++;
      $display("FAIL reset_regs: got pc=%h ir=%h state=%0d trap=%b retired=%0d expected pc=%h ir=0 state=0 trap=0 retired=0",
               pc, ir, state, trap, retired, RV);
    end
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL reset_release_fetch: got mem_req=%b expected 1", mem_req);
    end
  endtask

  task automatic test_add;
    run_instr(32'h0022_1820, 0, 0, 1'b0, 32'h0);
    checks++;
    if (obs_timeout || obs_cycles != 4) begin
      errors++; $display("FAIL add_cycles: got %0d (timeout=%0d) expected 4", obs_cycles, obs_timeout);
    end
    checks++;
    if (obs_states.size() != 4 || obs_states[0] !== 3'd0 || obs_states[1] !== 3'd1 ||
        obs_states[2] !== 3'd2 || obs_states[3] !== 3'd4) begin
      errors++; $display("FAIL add_states: got %p expected FETCH,DECODE,EXEC,WB", obs_states);
    end
    checks++;
    if (obs_regwe_cnt != 1 || obs_regwe_cyc != 4 || obs_dst !== 2'd1) begin
      errors++; $display("FAIL add_regwe: got cnt=%0d cyc=%0d dst=%0d expected cnt=1 cyc=4 dst=1",
                         obs_regwe_cnt, obs_regwe_cyc, obs_dst);
    end
    checks++;
    if (pc !== 32'h104 || retired !== 4'd1) begin
      errors++; $display("FAIL add_pc_retired: got pc=%h retired=%0d expected pc=104 retired=1", pc, retired);
    end
  endtask

  task automatic test_lw_wait;
    run_instr(32'h8C22_0004, 2, 3, 1'b0, 32'h0);
    checks++;
    if (obs_timeout || obs_cycles != 10) begin
      errors++; $display("FAIL lw_cycles: got %0d expected 10", obs_cycles);
    end
    checks++;
    if (obs_addrsel_cnt != 4 || obs_addrsel_bad != 0) begin
      errors++; $display("FAIL lw_addr_sel: got mem-cycles=%0d outside-mem=%0d expected 4 and 0",
                         obs_addrsel_cnt, obs_addrsel_bad);
    end
    checks++;
    if (obs_regwe_cnt != 1 || obs_wb !== 2'd1 || obs_dst !== 2'd0 || obs_memwe_cnt != 0) begin
      errors++; $display("FAIL lw_wb: got regwe=%0d wb=%0d dst=%0d memwe=%0d expected 1 1 0 0",
                         obs_regwe_cnt, obs_wb, obs_dst, obs_memwe_cnt);
    end
    checks++;
    if (pc !== 32'h108 || retired !== 4'd2) begin
      errors++; $display("FAIL lw_pc_retired: got pc=%h retired=%0d expected 108 2", pc, retired);
    end
  endtask

  task automatic test_branch;
    logic [31:0] instrs[6];
    logic        azs[6];
    logic [31:0] want[6];
    instrs = '{32'h0020_0008, 32'h1000_FFFF, 32'h1000_FFFF, 32'h0020_0008, 32'h1400_FFFF, 32'h1400_FFFF};
    azs    = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    want   = '{32'h200, 32'h200, 32'h204, 32'h200, 32'h200, 32'h204};
    for (int i = 0; i < 6; i++) begin
      run_instr(instrs[i], i % 2, 0, azs[i], 32'h200);
      checks++;
      if (obs_timeout || obs_cycles != 3 + (i % 2) || pc !== want[i]) begin
        errors++; $display("FAIL branch_%0d: got pc=%h cycles=%0d expected pc=%h cycles=%0d",
                           i, pc, obs_cycles, want[i], 3 + (i % 2));
      end
    end
    checks++;
    if (retired !== 4'd8) begin
      errors++; $display("FAIL branch_retired: got %0d expected 8", retired);
    end
  endtask

  task automatic test_jal;
    run_instr(32'h0020_0008, 0, 0, 1'b0, 32'h0040_0010);
    run_instr(32'h0C10_0000, 0, 0, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h0040_0000) begin
      errors++; $display("FAIL jal_pc: got %h expected 00400000", pc);
    end
    checks++;
    if (obs_regwe_cnt != 1 || obs_regwe_cyc != 3 || obs_dst !== 2'd2 || obs_wb !== 2'd2 ||
        obs_link !== 32'h0040_0014) begin
      errors++; $display("FAIL jal_link: got cnt=%0d cyc=%0d dst=%0d wb=%0d link=%h expected 1 3 2 2 00400014",
                         obs_regwe_cnt, obs_regwe_cyc, obs_dst, obs_wb, obs_link);
    end
    checks++;
    if (retired !== 4'd10) begin
      errors++; $display("FAIL jal_retired: got %0d expected 10", retired);
    end
  endtask

  task automatic test_trap;
    do_reset();
    run_instr(32'hFC00_0000, 1, 0, 1'b0, 32'h0);
    checks++;
    if (obs_timeout || state !== 3'd7 || trap !== 1'b1 || pc !== 32'h104 || retired !== 4'd0) begin
      errors++; $display("FAIL trap_opcode: got state=%0d trap=%b pc=%h retired=%0d expected 7 1 104 0",
                         state, trap, pc, retired);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      mem_ready = 1'b1; mem_rdata = $urandom(); rs_data = $urandom();
      alu_zero = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({mem_req, mem_we, reg_we, mem_addr_sel} !== 4'b0000) begin
        errors++; $display("FAIL trap_strobes_%0d: got %b expected 0000", i, {mem_req, mem_we, reg_we, mem_addr_sel});
      end
      @(posedge clock); #1;
      checks++;
      if (pc !== 32'h104 || ir !== 32'hFC00_0000 || state !== 3'd7 || trap !== 1'b1) begin
        errors++; $display("FAIL trap_frozen_%0d: got pc=%h ir=%h state=%0d trap=%b", i, pc, ir, state, trap);
      end
    end
    do_reset();
    #1;
    checks++;
    if (trap !== 1'b0 || pc !== RV || state !== 3'd0 || mem_req !== 1'b1) begin
      errors++; $display("FAIL trap_clear: got trap=%b pc=%h state=%0d mem_req=%b expected 0 %h 0 1",
                         trap, pc, state, mem_req, RV);
    end
    run_instr(32'h0020_0008, 0, 0, 1'b0, 32'h0000_1002);
    checks++;
    if (obs_timeout || state !== 3'd7 || trap !== 1'b1 || pc !== 32'h104 || retired !== 4'd0) begin
      errors++; $display("FAIL trap_jr: got state=%0d trap=%b pc=%h retired=%0d expected 7 1 104 0",
                         state, trap, pc, retired);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_sw;
    bit in_mem;
    in_mem = 0;
    mem_rdata = 32'hAC22_0008;
    for (int i = 0; i < 20 && !in_mem; i++) begin
      @(negedge clock);
      if (state == 3'd3) in_mem = 1;
      else mem_ready = 1'b1;
    end
    checks++;
    if (!in_mem || mem_we !== 1'b1) begin
      errors++; $display("FAIL sw_reach_mem: got in_mem=%0d mem_we=%b expected 1 1", in_mem, mem_we);
    end
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (mem_we !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL sw_reset_strobes: got mem_we=%b mem_req=%b expected 0 0", mem_we, mem_req);
    end
    @(posedge clock); #1;
    checks++;
    if (state !== 3'd0 || pc !== RV || retired !== 4'd0 || ir !== 32'h0) begin
      errors++; $display("FAIL sw_reset_state: got state=%0d pc=%h retired=%0d ir=%h expected 0 %h 0 0",
                         state, pc, retired, ir, RV);
    end
    @(negedge clock);
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 16; i++) begin
      run_instr(32'h2022_0001, 0, 0, 1'b0, 32'h0);
      checks++;
      if (obs_timeout || retired !== 4'(i + 1)) begin
        errors++; $display("FAIL wrap_%0d: got retired=%0d expected %0d", i, retired, (i + 1) % 16);
      end
    end
  endtask

  task automatic test_random;
    logic [5:0]  functs[5];
    logic [31:0] m_pc, instr, rsd;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic        az;
    int          m_ret, k, fw, mw;
    exp_t        e;
    functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    do_reset();
    m_pc = RV;
    m_ret = 0;
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 12);
      rs = 5'($urandom()); rt = 5'($urandom()); rd = 5'($urandom());
      imm = 16'($urandom()); tgt = 26'($urandom());
      fw = $urandom_range(0, 3); mw = $urandom_range(0, 3);
      az = 1'($urandom_range(0, 1));
      rsd = $urandom();
      case (k)
        0, 1, 2, 3, 4: instr = {6'h00, rs, rt, rd, 5'd0, functs[k]};
        5: begin instr = {6'h00, rs, 15'd0, 6'h08}; rsd = rsd & 32'hFFFF_FFFC; end
        6: instr = {6'h08, rs, rt, imm};
        7: instr = {6'h23, rs, rt, imm};
        8: instr = {6'h2B, rs, rt, imm};
        9: instr = {6'h04, rs, rt, imm};
        10: instr = {6'h05, rs, rt, imm};
        11: instr = {6'h02, tgt};
        default: instr = {6'h03, tgt};
      endcase
      e = predict(m_pc, instr, fw, mw, az, rsd);
      run_instr(instr, fw, mw, az, rsd);
      checks++;
      if (obs_timeout || obs_cycles != e.cycles) begin
        errors++; $display("FAIL rnd_cycles_%0d: instr=%h got %0d expected %0d", n, instr, obs_cycles, e.cycles);
      end
      checks++;
      if (pc !== e.npc || trap !== e.trap) begin
        errors++; $display("FAIL rnd_pc_%0d: instr=%h got pc=%h trap=%b expected pc=%h trap=%b",
                           n, instr, pc, trap, e.npc, e.trap);
      end
      checks++;
      if (obs_regwe_cnt != e.regwe || obs_memwe_cnt != e.memwe || obs_addrsel_cnt != e.addrsel ||
          obs_imm_cnt != e.imm_cyc || obs_sub_cnt != e.sub_cyc) begin
        errors++; $display("FAIL rnd_strobes_%0d: instr=%h got regwe=%0d memwe=%0d addr=%0d imm=%0d sub=%0d expected %0d %0d %0d %0d %0d",
                           n, instr, obs_regwe_cnt, obs_memwe_cnt, obs_addrsel_cnt, obs_imm_cnt, obs_sub_cnt,
                           e.regwe, e.memwe, e.addrsel, e.imm_cyc, e.sub_cyc);
      end
      if (e.regwe != 0) begin
        checks++;
        if (obs_regwe_cyc != e.regwe_at || obs_dst !== e.dst || obs_wb !== e.wb ||
            (e.wb == 2'd2 && obs_link !== e.link)) begin
          errors++; $display("FAIL rnd_wb_%0d: instr=%h got cyc=%0d dst=%0d wb=%0d link=%h expected %0d %0d %0d %h",
                             n, instr, obs_regwe_cyc, obs_dst, obs_wb, obs_link, e.regwe_at, e.dst, e.wb, e.link);
        end
      end
      if (e.retire) m_ret = (m_ret + 1) % 16;
      checks++;
      if (retired !== 4'(m_ret)) begin
        errors++; $display("FAIL rnd_retired_%0d: got %0d expected %0d", n, retired, m_ret);
      end
      m_pc = e.npc;
      if (obs_timeout || e.trap) begin
        do_reset();
        m_pc = RV;
        m_ret = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_branch();
    test_jal();
    test_trap();
    test_reset_mid_sw();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle instruction sequencer for the MIPS subset core.
- Successor to the fixed single-cycle PC/next-PC path: owns the PC and instruction register, runs a FETCH/DECODE/EXEC/MEM/WB state machine, and drives datapath control strobes.
- Tolerates variable-latency memory through a req/ready handshake.
- Adds jump, jal, jr, bne, a parametrised reset vector, a trap state and a retired-instruction counter.

Parameters:
- XLEN, 32, datapath/PC width; legal values 32 or 64.
- RESET_VECTOR, 0, PC value loaded on reset; must be a multiple of 4.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_rdata  in  32  instruction word from unified memory port.
- mem_ready  in  1  memory completes current request this cycle.
- alu_zero  in  1  ALU zero flag, valid in EXEC.
- rs_data  in  XLEN  register-file read port 1, used as target for jr.
- pc  out  XLEN  current program counter.
- ir  out  32  latched instruction register.
- mem_req  out  1  memory request active.
- mem_we  out  1  write strobe; qualifies mem_req.
- mem_addr_sel  out  1  0 = address from pc, 1 = address from ALU result.
- reg_we  out  1  register-file write enable, single-cycle pulse.
- dst_sel  out  2  write address select: 0 = rt, 1 = rd, 2 = register 31.
- wb_sel  out  2  write data select: 0 = ALU, 1 = memory, 2 = pc (link).
- alu_src_imm  out  1  ALU operand 2 is sign-extended immediate.
- alu_mode  out  2  0 = add, 1 = sub, 2 = decode funct.
- state  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP.
- trap  out  1  illegal instruction seen; sticky.
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W.

Behaviour:
- Reset (synchronous, priority over everything, valid mid-transaction):
  - pc=RESET_VECTOR, ir=0, state=FETCH, trap=0, retired=0.
  - All strobes 0 in the cycle reset is asserted.
  - An in-flight memory request is abandoned; a mem_ready seen in the reset cycle is ignored.
- Strobes are combinational from state and ir; pc, ir, state, trap and retired are registers.
- FETCH:
  - mem_req=1, mem_addr_sel=0.
  - Holds while mem_ready=0 (any number of wait cycles).
  - On mem_ready: ir<=mem_rdata, pc<=pc+4, go to DECODE.
- DECODE: one cycle, no strobes. Decodes ir[31:26] and, for R-type, ir[5:0].
  - Legal: R-type 0x00 (funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt, 0x08 jr), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, bne 0x05, j 0x02, jal 0x03.
  - Anything else → TRAP.
- EXEC:
  - R-type: alu_mode=2 → WB.
  - addi/lw/sw: alu_src_imm=1, alu_mode=0; addi → WB, lw/sw → MEM.
  - beq/bne: alu_mode=1. If taken (beq with alu_zero=1, bne with alu_zero=0), pc<=pc+(sext(ir[15:0])<<2), using XLEN-bit arithmetic with wrap. Then → FETCH, retired+1.
  - j: pc<={pc[XLEN-1:28], ir[25:0], 2'b00}, → FETCH, retired+1.
  - jal: same pc update; reg_we=1, dst_sel=2, wb_sel=2, writing the pre-update pc (already +4). → FETCH, retired+1.
  - jr: pc<=rs_data, → FETCH, retired+1. If rs_data[1:0]≠0, → TRAP instead and pc is unchanged.
- MEM:
  - mem_req=1, mem_addr_sel=1, alu_src_imm=1, alu_mode=0 held; mem_we=1 for sw.
  - Holds until mem_ready.
  - sw → FETCH, retired+1; lw → WB.
- WB:
  - reg_we=1, one cycle.
  - R-type: dst_sel=1, wb_sel=0. addi: dst_sel=0, wb_sel=0. lw: dst_sel=0, wb_sel=1.
  - Exception: R-type writing rd=0 still pulses reg_we; the regfile discards writes to register 0.
  - → FETCH, retired+1.
- TRAP: trap=1, all strobes 0, pc and ir frozen; exit only by reset.
- Zero-wait latencies:
  - branch/j/jal/jr: 3 cycles.
  - R-type, addi, sw: 4 cycles.
  - lw: 5 cycles.
  - Each mem_ready=0 cycle adds one.
- retired increments exactly once per completed instruction and wraps from all-ones to 0. Trapped instructions are not counted.

Test Plan:
- Reset with RESET_VECTOR=0x100, then R-type add with zero wait: states FETCH,DECODE,EXEC,WB. reg_we high only in cycle 4 with dst_sel=1. pc=0x104, retired=1.
- lw with mem_ready held low 2 cycles in FETCH and 3 in MEM: total 10 cycles. mem_addr_sel=1 only in MEM, reg_we with wb_sel=1 once, mem_we never asserted.
- beq at pc=0x200 with imm=0xFFFF: alu_zero=1 gives pc=0x200; alu_zero=0 gives pc=0x204. bne with the same imm inverts the result.
- jal at 0x00400010, target field 0x0100000: pc=0x00400000, reg_we with dst_sel=2, wb_sel=2 in EXEC, link value 0x00400014.
- Opcode 0x3F, and jr with rs_data=0x1002: state=7, trap=1, pc frozen, retired unchanged. Reset clears trap and restarts fetch at RESET_VECTOR.
- Reset asserted during MEM of sw while mem_ready=1: no mem_we in the reset cycle, state=FETCH next cycle. With CNT_W=4, run 16 instructions and confirm retired wraps to 0.
